// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate self-check driver.
package gate_chk_pkg;

  localparam int NUM_PATTERNS = 4;
  localparam int IDX_W        = 2;
  localparam int CNT_W        = 4;

  // Expected Z per pattern index i, where A=i[0] and B=i[1]
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PATTERNS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
      if (m[NUM_PATTERNS-1-i]) r = IDX_W'(NUM_PATTERNS-1-i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Loadable down-counter; zero flag marks the sample edge of each pattern.
module gate_chk_settle_cnt
  import gate_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_chk_driver.sv
// Drives the four {B,A} patterns into a 2-input gate and checks Z against TRUTH_TABLE.
// Optional error log (err_cnt, first_fail_idx) under GATE_CHK_ERRLOG_EN.
module gate_chk_driver
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_XOR,
  parameter int unsigned SETTLE_CYCLES = 2
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
`ifdef GATE_CHK_ERRLOG_EN
  ,
  output logic [7:0] err_cnt,
  output logic [1:0] first_fail_idx
`endif
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_PATTERNS - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             a_n, b_n, busy_n, done_n, pass_n;
  logic [3:0]       mask_n;
  logic             cnt_load, cnt_zero;
  logic             mis;

  gate_chk_settle_cnt u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  // X/Z on the gate output must count as a mismatch in simulation
`ifdef SYNTHESIS
  assign mis = (Z != TRUTH_TABLE[idx]);
`else
  assign mis = (Z !== TRUTH_TABLE[idx]);
`endif

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    a_n      = A;
    b_n      = B;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    mask_n   = fail_mask;
    cnt_load = 1'b0;
    case (state)
      IDLE: begin
        a_n    = 1'b0;
        b_n    = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          state_n  = RUN;
          idx_n    = '0;
          cnt_load = 1'b1;
          busy_n   = 1'b1;
          mask_n   = '0;
          pass_n   = 1'b0;
        end
      end
      RUN: begin
        if (cnt_zero) begin
          if (mis) mask_n[idx] = 1'b1;
          if (idx != LAST) begin
            idx_n    = idx + IDX_W'(1);
            cnt_load = 1'b1;
            {b_n, a_n} = idx_n;
          end else begin
            state_n = FIN;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            pass_n  = (mask_n == '0);
            a_n     = 1'b0;
            b_n     = 1'b0;
          end
        end
      end
      FIN: begin
        state_n = IDLE;
        a_n     = 1'b0;
        b_n     = 1'b0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        a_n     = 1'b0;
        b_n     = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      A         <= a_n;
      B         <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      fail_mask <= mask_n;
    end
  end

`ifdef GATE_CHK_ERRLOG_EN
  logic sample, finish;
  assign sample = (state == RUN) && cnt_zero;
  assign finish = sample && (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_fail_idx <= '0;
    end else begin
      if (sample && mis && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;
      if ((state == IDLE) && start) begin
        first_fail_idx <= '0;
      end else if (finish) begin
        first_fail_idx <= lowest_set(mask_n);
      end
    end
  end
`endif

endmodule

// File: doc/gate_chk_driver.md
Name: gate_chk_driver

Overview:
- Hardware stimulus/response end for the mux-built 2-input gates (xor_mux and siblings).
- On a start pulse, drives all four {B,A} input combinations into a gate under test and samples its Z output after a settle interval.
- Compares each sampled Z against a parameterised truth table, then reports pass/fail and a per-pattern fail mask.
- Sits beside the gate instance as an on-chip self-check, replacing an open-loop simulation-only stimulus sequence.

Parameters:
- TRUTH_TABLE, 4'b0110: expected Z per pattern index i, where A=i[0] and B=i[1]. The default is XOR; AND is 4'b1000, OR is 4'b1110.
- SETTLE_CYCLES, 2: clock cycles each pattern is held before Z is sampled. Legal range 1..15.

Ports:
- clk  input  1: single clock, rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- start  input  1: one-cycle request to run the four-pattern sequence.
- A  output  1: gate-under-test input A (registered).
- B  output  1: gate-under-test input B (registered).
- Z  input  1: gate-under-test output.
- busy  output  1: high while the sequence runs.
- done  output  1: one-cycle pulse when the sequence completes.
- pass  output  1: sticky result, 1 when all four patterns matched; valid from done until the next accepted start.
- fail_mask  output  4: bit i is set when pattern i mismatched; same validity as pass.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - A=0, B=0, busy=0, done=0, pass=0, fail_mask=0.
  - Pattern index and settle counter are cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - A=B=0, busy=0.
  - start=1 is accepted: move to RUN, idx=0, A=0, B=0, cnt=SETTLE_CYCLES-1, busy=1, fail_mask=0, pass=0.
- RUN:
  - {B,A} = idx, registered.
  - Each cycle with cnt!=0: decrement cnt.
  - Edge with cnt==0: Z is sampled at this edge.
    - If Z != TRUTH_TABLE[idx], set fail_mask[idx].
    - If idx<3: idx increments, {B,A} takes the new idx at the same edge, and cnt reloads to SETTLE_CYCLES-1.
    - If idx==3: go to FIN.
  - Each pattern is therefore held exactly SETTLE_CYCLES cycles.
  - Order: (A,B) = 00, 10, 01, 11.
- FIN (one cycle):
  - done=1, busy=0, pass = (fail_mask==0), including the final sample's update.
  - A=B=0.
  - Return to IDLE next cycle.
- Latency: start accepted at edge t0; done is high in the cycle after edge t0+4*SETTLE_CYCLES.
- start while busy or in FIN: ignored, with no restart and no effect on results.
- start together with reset asserted: reset wins.
- rst_n asserted mid-run: immediate abort to reset values; no done pulse.
- Z with X/Z value: treated as a mismatch. Compare with the case-inequality operator in simulation; synthesis has plain compare.
- No combinational path from Z to any output; all outputs are registered.

Optional Feature:
- Macro: GATE_CHK_ERRLOG_EN
- When defined, adds two outputs:
  - err_cnt (8 bits): saturating count of mismatched samples accumulated across all runs. Saturates at 8'hFF and clears only on rst_n.
  - first_fail_idx (2 bits): index of the lowest-numbered failing pattern in the last run. Valid when pass=0 after done, otherwise 0.
- When undefined, neither port exists and no counter logic is present. Core behaviour is identical in both builds.

Decomposition:
- Shared package gate_chk_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - constants NUM_PATTERNS=4, IDX_W=2, CNT_W=4;
  - the truth-table constants for XOR, AND, OR, NAND and NOR, for bench and instance reuse.
- One natural sub-module, gate_chk_settle_cnt: a loadable down-counter with a zero flag that provides the sample strobe.
- FSM and comparison stay in the top module.

Test Plan:
- XOR, default params, with xor_mux attached; start at cycle 5:
  - A,B follow 00,10,01,11, each held 2 cycles;
  - done at the cycle after edge 5+8;
  - pass=1, fail_mask=4'b0000.
- TRUTH_TABLE=4'b0110 with Z tied to 0:
  - fail_mask=4'b0110, pass=0;
  - with ERRLOG, err_cnt=2 and first_fail_idx=1.
- SETTLE_CYCLES=1 with an AND gate and TRUTH_TABLE=4'b1000:
  - A/B change every cycle, done 4 cycles after start, pass=1.
- start pulsed again on the 3rd busy cycle:
  - ignored; done occurs exactly once, at the unmodified time.
- rst_n pulled low during pattern 2:
  - A=B=0, busy=0, pass=0 asynchronously, no done;
  - a new start after release runs a clean full sequence with pass=1.
- ERRLOG with Z tied to 1 and XOR table, 200 runs:
  - err_cnt saturates at 8'hFF and stays there;
  - fail_mask=4'b1001 on each run.
